// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   MAX_NREQ : largest supported requester count
//   PTR_W    : width of the round-robin pointer (covers MAX_NREQ)
//   CNT_W    : width of the stall timeout counter
//   state_t  : FSM state encoding (ST_IDLE, ST_SEND)
package uart_tx_arb_pkg;
  localparam int MAX_NREQ = 8;
  localparam int PTR_W    = 3;
  localparam int CNT_W    = 12;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_SEND = 1'b1;
endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker.
//   valid  : request vector
//   rr_ptr : index of the last served requester
//   sel    : one-hot selection, first valid bit searching from rr_ptr+1
//            (mod NREQ); all zero when nothing is valid
module rr_picker
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [NREQ-1:0]  sel
);

  int   idx;
  logic found;

  // Constant inner index keeps every bit-select static.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (!found && (j == idx) && valid[j]) begin
          sel[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter in front of uart_fifoed_send.
//   clk_100MHz, reset        : clock, synchronous active-high reset
//   req_valid/data/last      : NREQ byte lanes (lane i = req_data[8i+7:8i])
//   req_ready                : lane i byte accepted when valid && ready
//   grant                    : one-hot owner, zero when idle
//   busy                     : high in SEND
//   timeout_pulse            : one-cycle pulse after a stalled owner is dropped
//   dat_en, dat              : registered write strobe/byte to the UART
//   fifo_full                : UART FIFO full
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 4095
) (
  input  logic              clk_100MHz,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              timeout_pulse,
  output logic              dat_en,
  output logic [7:0]        dat,
  input  logic              fifo_full
);

  state_t             state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         dat_q, dat_d;
  logic               dat_en_q, dat_en_d;
  logic               tpulse_q, tpulse_d;

  logic [NREQ-1:0]    pick;
  logic               owner_valid, owner_last;
  logic [7:0]         owner_data;
  logic [PTR_W-1:0]   owner_idx;
  logic               send_ok, xfer, tmo_hit;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .valid  (req_valid),
    .rr_ptr (rr_ptr_q),
    .sel    (pick)
  );

  always_comb begin
    owner_data = 8'h00;
    owner_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        owner_data = req_data[8*i +: 8];
        owner_idx  = PTR_W'(i);
      end
    end
  end

  assign owner_valid = |(req_valid & grant_q);
  assign owner_last  = |(req_last & grant_q);

  // The dat_en gap spaces writes so fifo_full always reflects the previous one.
  assign send_ok = (state_q == ST_SEND) && !fifo_full && !dat_en_q;
  assign xfer    = send_ok && owner_valid;
  // Only cycles with the owner's valid low advance the counter, so a
  // FIFO-full or pacing stall can never cause a release.
  assign tmo_hit = (state_q == ST_SEND) && !owner_valid &&
                   (cnt_q == CNT_W'(TIMEOUT - 1));

  assign req_ready     = send_ok ? grant_q : '0;
  assign grant         = grant_q;
  assign busy          = (state_q == ST_SEND);
  assign timeout_pulse = tpulse_q;
  assign dat_en        = dat_en_q;
  assign dat           = dat_q;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    dat_d    = dat_q;
    dat_en_d = 1'b0;
    tpulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (|req_valid) begin
          grant_d = pick;
          state_d = ST_SEND;
        end
      end
      default: begin
        if (xfer) begin
          dat_d    = owner_data;
          dat_en_d = 1'b1;
          cnt_d    = '0;
          if (owner_last) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            rr_ptr_d = owner_idx;
          end
        end else if (tmo_hit) begin
          state_d  = ST_IDLE;
          grant_d  = '0;
          rr_ptr_d = owner_idx;
          tpulse_d = 1'b1;
          cnt_d    = '0;
        end else if (!owner_valid) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= PTR_W'(NREQ - 1);
      cnt_q    <= '0;
      dat_q    <= 8'h00;
      dat_en_q <= 1'b0;
      tpulse_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      dat_q    <= dat_d;
      dat_en_q <= dat_en_d;
      tpulse_q <= tpulse_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=3, TIMEOUT=16).
module tb_uart_tx_arbiter;
  localparam int NREQ = 3;
  localparam int TMO  = 16;

  logic              clk_100MHz = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              busy, timeout_pulse, dat_en;
  logic [7:0]        dat;
  logic              fifo_full;

  uart_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk_100MHz    (clk_100MHz),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .grant         (grant),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .dat_en        (dat_en),
    .dat           (dat),
    .fifo_full     (fifo_full)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int errors = 0;
  int checks = 0;

  logic [8:0]      lane_q [NREQ][$];   // {last, data} per lane
  logic [7:0]      exp_q[$];          // expected UART byte order
  logic [NREQ-1:0] grant_log[$];
  logic [NREQ-1:0] lane_en;
  logic            prev_dat_en = 1'b0;
  logic [NREQ-1:0] prev_grant = '0;

  typedef struct {
    int        prev;
    logic [2:0] mask;
    logic [2:0] exp_grant;
  } rr_vec_t;
  rr_vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Lane driver: presents the head of each enabled lane queue after every edge.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(posedge clk_100MHz);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (lane_en[i] && lane_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = lane_q[i][0][7:0];
          req_last[i]        = lane_q[i][0][8];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  // Monitor: handshakes, scoreboard, invariants.
  always @(negedge clk_100MHz) begin
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i] && lane_q[i].size() > 0)
        void'(lane_q[i].pop_front());
    chk("ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
    if (dat_en) begin
      chk("strobe_spacing", 32'(prev_dat_en), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: dat=%02h with no byte expected", dat);
      end else begin
        chk("dat", 32'(dat), 32'(exp_q.pop_front()));
      end
    end
    prev_dat_en = dat_en;
    if (grant != '0 && grant != prev_grant) grant_log.push_back(grant);
    prev_grant = grant;
  end

  task automatic push_byte(input int lane, input logic [7:0] b, input logic last, input bit expect_it);
    lane_q[lane].push_back({last, b});
    if (expect_it) exp_q.push_back(b);
  endtask

  task automatic sync_point();
    @(posedge clk_100MHz);
    #2;
  endtask

  task automatic neg(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  task automatic wait_idle(input string name);
    int  n;
    bit  done;
    bit  empty;
    n    = 0;
    done = 0;
    while (!done && n < 400) begin
      @(negedge clk_100MHz);
      n++;
      empty = 1;
      for (int i = 0; i < NREQ; i++) if (lane_q[i].size() != 0) empty = 0;
      if (empty && !busy && !dat_en && exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: not idle after 400 cycles (busy=%0b, pending=%0d)", name, busy, exp_q.size());
      for (int i = 0; i < NREQ; i++) lane_q[i].delete();
      exp_q.delete();
    end
    neg(2);
  endtask

  task automatic do_reset();
    sync_point();
    reset = 1'b1;
    repeat (2) @(posedge clk_100MHz);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int idle_cnt, strobe_cnt, lane;
    bit seen;

    vecs[0] = '{prev: 0, mask: 3'b111, exp_grant: 3'b010};
    vecs[1] = '{prev: 1, mask: 3'b111, exp_grant: 3'b100};
    vecs[2] = '{prev: 2, mask: 3'b111, exp_grant: 3'b001};
    vecs[3] = '{prev: 0, mask: 3'b101, exp_grant: 3'b100};
    vecs[4] = '{prev: 2, mask: 3'b110, exp_grant: 3'b010};
    vecs[5] = '{prev: 1, mask: 3'b001, exp_grant: 3'b001};
    vecs[6] = '{prev: 1, mask: 3'b010, exp_grant: 3'b010};

    reset     = 1'b1;
    fifo_full = 1'b0;
    lane_en   = '1;
    repeat (3) @(posedge clk_100MHz);
    neg(1);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tpulse", 32'(timeout_pulse), 32'd0);
    chk("rst_dat_en", 32'(dat_en), 32'd0);
    chk("rst_dat", 32'(dat), 32'd0);
    @(posedge clk_100MHz);
    #2;
    reset = 1'b0;

    // "AB" from requester 0: strobes at t+2 and t+4
    sync_point();
    push_byte(0, 8'h41, 1'b0, 1);
    push_byte(0, 8'h42, 1'b1, 1);
    neg(2);
    chk("ab_grant_t0", 32'(grant), 32'd0);
    neg(1);
    chk("ab_grant_t1", 32'(grant), 32'b001);
    chk("ab_busy_t1", 32'(busy), 32'd1);
    chk("ab_ready_t1", 32'(req_ready), 32'b001);
    neg(1);
    chk("ab_dat_en_t2", 32'(dat_en), 32'd1);
    chk("ab_dat_t2", 32'(dat), 32'h41);
    chk("ab_ready_gap_t2", 32'(req_ready), 32'd0);
    neg(1);
    chk("ab_dat_en_t3", 32'(dat_en), 32'd0);
    chk("ab_ready_t3", 32'(req_ready), 32'b001);
    neg(1);
    chk("ab_dat_en_t4", 32'(dat_en), 32'd1);
    chk("ab_dat_t4", 32'(dat), 32'h42);
    chk("ab_grant_t4", 32'(grant), 32'd0);
    chk("ab_busy_t4", 32'(busy), 32'd0);
    wait_idle("ab_drain");

    // Round-robin table: prev owner sets rr_ptr, then simultaneous requests
    for (int v = 0; v < 7; v++) begin
      push_byte(vecs[v].prev, 8'hA0 + 8'(v), 1'b1, 1);
      wait_idle("rr_prev");
      sync_point();
      for (int k = 1; k <= NREQ; k++) begin
        lane = (vecs[v].prev + k) % NREQ;
        if (vecs[v].mask[lane]) push_byte(lane, 8'hC0 + 8'(v * 4 + lane), 1'b1, 1);
      end
      neg(3);
      chk("rr_grant", 32'(grant), 32'(vecs[v].exp_grant));
      wait_idle("rr_drain");
    end

    // Three concurrent 2-byte messages from reset, plus a second from lane 0
    do_reset();
    grant_log.delete();
    push_byte(0, 8'h11, 1'b0, 1); push_byte(0, 8'h12, 1'b1, 1);
    push_byte(1, 8'h21, 1'b0, 1); push_byte(1, 8'h22, 1'b1, 1);
    push_byte(2, 8'h31, 1'b0, 1); push_byte(2, 8'h32, 1'b1, 1);
    push_byte(0, 8'h13, 1'b0, 1); push_byte(0, 8'h14, 1'b1, 1);
    wait_idle("conc_drain");
    chk("conc_grant_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("conc_grant0", 32'(grant_log[0]), 32'b001);
      chk("conc_grant1", 32'(grant_log[1]), 32'b010);
      chk("conc_grant2", 32'(grant_log[2]), 32'b100);
      chk("conc_grant3", 32'(grant_log[3]), 32'b001);
    end

    // Timeout: owner 0 goes silent after its first byte, lane 1 waiting
    do_reset();
    sync_point();
    push_byte(0, 8'h51, 1'b0, 1);
    push_byte(0, 8'h52, 1'b1, 0);
    push_byte(1, 8'h61, 1'b1, 1);
    neg(3);
    chk("tmo_first_ready", 32'(req_ready), 32'b001);
    lane_en[0] = 1'b0;
    for (int j = 1; j <= TMO; j++) begin
      neg(1);
      chk("tmo_no_pulse_early", 32'(timeout_pulse), 32'd0);
    end
    neg(1);
    chk("tmo_pulse", 32'(timeout_pulse), 32'd1);
    chk("tmo_released", 32'(busy), 32'd0);
    neg(1);
    chk("tmo_next_grant", 32'(grant), 32'b010);
    chk("tmo_pulse_single", 32'(timeout_pulse), 32'd0);
    lane_q[0].delete();
    lane_en[0] = 1'b1;
    wait_idle("tmo_drain");

    // fifo_full held for 50 cycles mid-message
    sync_point();
    push_byte(2, 8'h71, 1'b0, 1);
    push_byte(2, 8'h72, 1'b0, 1);
    push_byte(2, 8'h73, 1'b1, 1);
    seen = 0;
    for (int j = 0; j < 20 && !seen; j++) begin
      neg(1);
      if (dat_en) seen = 1;
    end
    chk("ff_first_strobe", 32'(seen), 32'd1);
    fifo_full = 1'b1;
    for (int j = 0; j < 50; j++) begin
      neg(1);
      chk("ff_ready_low", 32'(req_ready), 32'd0);
      chk("ff_no_timeout", 32'(timeout_pulse), 32'd0);
    end
    chk("ff_still_busy", 32'(busy), 32'd1);
    fifo_full = 1'b0;
    wait_idle("ff_drain");

    // Reset right after the first transfer: strobe suppressed, grant dropped
    sync_point();
    push_byte(0, 8'h41, 1'b0, 0);
    push_byte(0, 8'h42, 1'b1, 0);
    neg(3);
    chk("rst_mid_ready", 32'(req_ready), 32'b001);
    reset = 1'b1;
    neg(1);
    chk("rst_mid_grant", 32'(grant), 32'd0);
    chk("rst_mid_dat_en", 32'(dat_en), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    lane_q[0].delete();
    @(posedge clk_100MHz);
    #2;
    reset = 1'b0;
    wait_idle("rst_mid_drain");

    // 20 single-byte messages from requester 1
    sync_point();
    for (int n = 0; n < 20; n++) push_byte(1, 8'h80 + 8'(n), 1'b1, 1);
    neg(1);
    idle_cnt   = 0;
    strobe_cnt = 0;
    for (int c = 0; c <= 40; c++) begin
      neg(1);
      if (c < 40 && !busy) idle_cnt++;
      if (c >= 1 && dat_en) strobe_cnt++;
    end
    chk("stream_idle_cycles", 32'(idle_cnt), 32'd20);
    chk("stream_strobes", 32'(strobe_cnt), 32'd20);
    wait_idle("stream_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
